// File: rtl/josh_pkg.sv
// Shared types and constants for the playfield scanner and its neighbours.
// Holds the sweep state encoding, default colours and screen geometry.
package josh_pkg;

  typedef enum logic [2:0] {IDLE, WALL, DRAIN, SPRITE, DONE} state_e;

  localparam logic [2:0] WALL_COLOUR_DEF   = 3'b111;
  localparam logic [2:0] BG_COLOUR_DEF     = 3'b000;
  localparam logic [2:0] SPRITE_COLOUR_DEF = 3'b100;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

endpackage

// File: rtl/playfield_scanner_if.sv
// Synchronous bitmap RAM read port: the scanner is master, the RAM is slave.
// rd_data is valid exactly one cycle after rd_en.
interface playfield_scanner_if #(parameter int AW = 4);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/playfield_scanner_scan_counter_2d.sv
// Column-major 2D counter: row is the inner index, col the outer one.
// last flags the final (W-1, H-1) position; step past it wraps to (0, 0).
module scan_counter_2d #(
  parameter  int W   = 4,
  parameter  int H   = 6,
  localparam int CWD = (W > 1) ? $clog2(W) : 1,
  localparam int RWD = (H > 1) ? $clog2(H) : 1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           clear,
  input  logic           step,
  output logic [CWD-1:0] col,
  output logic [RWD-1:0] row,
  output logic           last
);

  localparam logic [CWD-1:0] COL_MAX = CWD'(W - 1);
  localparam logic [RWD-1:0] ROW_MAX = RWD'(H - 1);

  logic [CWD-1:0] col_q, col_d;
  logic [RWD-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (step) begin
      if (row_q == ROW_MAX) begin
        row_d = '0;
        col_d = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/playfield_scanner.sv
// Frame sweep: reads the wall bitmap column-major through a circular column
// base, plots each pixel one cycle later, then overlays a clipped sprite.
module playfield_scanner
  import josh_pkg::*;
#(
  parameter int COLS     = 120,
  parameter int ROWS     = 100,
  parameter int X_OFF    = 20,
  parameter int Y_OFF    = 10,
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 6,
  parameter int COLOUR_W = 3,
  parameter logic [COLOUR_W-1:0] WALL_COLOUR   = COLOUR_W'(WALL_COLOUR_DEF),
  parameter logic [COLOUR_W-1:0] BG_COLOUR     = COLOUR_W'(BG_COLOUR_DEF),
  parameter logic [COLOUR_W-1:0] SPRITE_COLOUR = COLOUR_W'(SPRITE_COLOUR_DEF)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [$clog2(COLS)-1:0]   scroll_base,
  input  logic [7:0]                sprite_x,
  input  logic [7:0]                sprite_y,
  input  logic                      sprite_en,
  playfield_scanner_if.master       ram,
  output logic                      plot,
  output logic [7:0]                x,
  output logic [7:0]                y,
  output logic [COLOUR_W-1:0]       colour,
  output logic                      busy,
  output logic                      done
);

  localparam int CW  = $clog2(COLS);
  localparam int AW  = $clog2(COLS * ROWS);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SCW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int SRW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [CW:0] COLS_W = (CW+1)'(COLS);

  state_e          state_q, state_d;
  logic [CW-1:0]   base_q, base_d;
  logic [7:0]      sx_q, sx_d, sy_q, sy_d;
  logic            en_q, en_d;
  logic            wall_vld_q, wall_vld_d;
  logic [7:0]      wx_q, wx_d, wy_q, wy_d;
  logic [7:0]      hx_q, hx_d, hy_q, hy_d;
  logic [COLOUR_W-1:0] hc_q, hc_d;

  logic            wall_step, spr_step, cnt_clear;
  logic [CW-1:0]   wcol;
  logic [RW-1:0]   wrow;
  logic            wall_last;
  logic [SCW-1:0]  scol;
  logic [SRW-1:0]  srow;
  logic            spr_last;

  assign cnt_clear = (state_q == IDLE);

  scan_counter_2d #(.W(COLS), .H(ROWS)) u_wall_cnt (
    .clk(clk), .resetn(resetn), .clear(cnt_clear), .step(wall_step),
    .col(wcol), .row(wrow), .last(wall_last)
  );

  scan_counter_2d #(.W(SPRITE_W), .H(SPRITE_H)) u_spr_cnt (
    .clk(clk), .resetn(resetn), .clear(cnt_clear), .step(spr_step),
    .col(scol), .row(srow), .last(spr_last)
  );

  // Circular base: base and column are both < COLS, so one conditional
  // subtract is enough to wrap.
  logic [CW:0]   phys_sum, phys_col;
  logic [AW-1:0] addr;
  assign phys_sum = {1'b0, base_q} + {1'b0, wcol};
  assign phys_col = (phys_sum >= COLS_W) ? phys_sum - COLS_W : phys_sum;
  assign addr     = AW'(phys_col) * AW'(ROWS) + AW'(wrow);

  assign ram.rd_en   = (state_q == WALL);
  assign ram.rd_addr = addr;

  // Sprite coordinates carry a ninth bit so right/bottom overflow clips.
  logic [8:0] spr_px, spr_py;
  logic       spr_plot;
  assign spr_px   = {1'b0, sx_q} + 9'(scol);
  assign spr_py   = {1'b0, sy_q} + 9'(srow);
  assign spr_plot = (state_q == SPRITE) && en_q &&
                    (spr_px < 9'(COLS)) && (spr_py < 9'(ROWS));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    en_d       = en_q;
    wx_d       = wx_q;
    wy_d       = wy_q;
    wall_step  = 1'b0;
    spr_step   = 1'b0;
    wall_vld_d = (state_q == WALL);
    case (state_q)
      IDLE: if (start) begin
        state_d = WALL;
        base_d  = ({1'b0, scroll_base} >= COLS_W) ? '0 : scroll_base;
        sx_d    = sprite_x;
        sy_d    = sprite_y;
        en_d    = sprite_en;
      end
      WALL: begin
        wall_step = 1'b1;
        wx_d      = 8'(X_OFF) + 8'(wcol);
        wy_d      = 8'(Y_OFF) + 8'(wrow);
        if (wall_last) state_d = DRAIN;
      end
      DRAIN:  state_d = SPRITE;
      SPRITE: begin
        spr_step = 1'b1;
        if (spr_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Non-plot cycles replay the last plotted pixel.
  always_comb begin
    x      = hx_q;
    y      = hy_q;
    colour = hc_q;
    if (wall_vld_q) begin
      x      = wx_q;
      y      = wy_q;
      colour = ram.rd_data ? WALL_COLOUR : BG_COLOUR;
    end else if (spr_plot) begin
      x      = 8'(X_OFF) + spr_px[7:0];
      y      = 8'(Y_OFF) + spr_py[7:0];
      colour = SPRITE_COLOUR;
    end
  end

  always_comb begin
    hx_d = x;
    hy_d = y;
    hc_d = colour;
  end

  assign plot = wall_vld_q | spr_plot;
  assign done = (state_q == DONE);
  assign busy = (state_q == WALL) || (state_q == DRAIN) || (state_q == SPRITE) ||
                ((state_q == IDLE) && start);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      base_q     <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      en_q       <= 1'b0;
      wall_vld_q <= 1'b0;
      wx_q       <= '0;
      wy_q       <= '0;
      hx_q       <= '0;
      hy_q       <= '0;
      hc_q       <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      en_q       <= en_d;
      wall_vld_q <= wall_vld_d;
      wx_q       <= wx_d;
      wy_q       <= wy_d;
      hx_q       <= hx_d;
      hy_q       <= hy_d;
      hc_q       <= hc_d;
    end
  end

endmodule

// File: tb/tb_playfield_scanner.sv
// Scoreboard bench: stimulus queues expected reads, plots and done cycles;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_playfield_scanner;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] scroll_base = '0;
  logic [7:0] sprite_x = '0, sprite_y = '0;
  logic       sprite_en = 1'b0;
  logic       plot, busy, done;
  logic [7:0] x, y;
  logic [2:0] colour;

  logic       start2 = 1'b0;
  logic [2:0] scroll_base2 = '0;
  logic [7:0] zero8 = '0;
  logic       zero1 = 1'b0;
  logic       plot2, busy2, done2;
  logic [7:0] x2, y2;
  logic [2:0] colour2;

  playfield_scanner_if #(.AW(4)) ram ();
  playfield_scanner_if #(.AW(4)) ram2 ();

  playfield_scanner #(.COLS(4), .ROWS(3)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .scroll_base(scroll_base),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
    .ram(ram), .plot(plot), .x(x), .y(y), .colour(colour),
    .busy(busy), .done(done)
  );

  playfield_scanner #(.COLS(5), .ROWS(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .scroll_base(scroll_base2),
    .sprite_x(zero8), .sprite_y(zero8), .sprite_en(zero1),
    .ram(ram2), .plot(plot2), .x(x2), .y(y2), .colour(colour2),
    .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  // Bitmap: bit k is set when k is odd.
  always @(posedge clk) begin
    if (ram.rd_en)  ram.rd_data  <= ram.rd_addr[0];
    if (ram2.rd_en) ram2.rd_data <= ram2.rd_addr[0];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int addr_q[$];
  int addr2_q[$];
  int done_q[$];
  logic [18:0] plot_q[$];
  logic [18:0] last_pix = '0;
  bit mon_en = 1'b0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ram.rd_en) begin
        if (addr_q.size() == 0) check("rd_en extra", int'(ram.rd_en), 0);
        else check("rd_addr", int'(ram.rd_addr), addr_q.pop_front());
      end
      if (plot) begin
        if (plot_q.size() == 0) check("plot extra", int'(plot), 0);
        else begin
          logic [18:0] e;
          e = plot_q.pop_front();
          check("plot x", int'(x), int'(e[18:11]));
          check("plot y", int'(y), int'(e[10:3]));
          check("plot colour", int'(colour), int'(e[2:0]));
          last_pix = e;
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("done extra", int'(done), 0);
        else begin
          check("done cycle", cyc, done_q.pop_front());
          if (!plot) check("hold xyc", int'({x, y, colour}), int'(last_pix));
        end
      end
      if (ram2.rd_en) begin
        if (addr2_q.size() == 0) check("rd_en2 extra", int'(ram2.rd_en), 0);
        else check("rd_addr2", int'(ram2.rd_addr), addr2_q.pop_front());
      end
    end
  end

  // Reference sweep for the 4x3 map with X_OFF=20, Y_OFF=10, 4x6 sprite.
  task automatic push_frame(int base, int sx, int sy, bit en, int t0);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 3; r++) begin
        int a;
        a = ((base + c) % 4) * 3 + r;
        addr_q.push_back(a);
        plot_q.push_back({8'(20 + c), 8'(10 + r), (a % 2 == 1) ? 3'b111 : 3'b000});
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 6; j++)
        if (en && (sx + i) < 4 && (sy + j) < 3)
          plot_q.push_back({8'(20 + sx + i), 8'(10 + sy + j), 3'b100});
    done_q.push_back(t0 + 38);
  endtask

  task automatic start_frame(int base, int sx, int sy, bit en);
    @(posedge clk); #1;
    scroll_base = 2'(base);
    sprite_x    = 8'(sx);
    sprite_y    = 8'(sy);
    sprite_en   = en;
    start       = 1'b1;
    push_frame(base, sx, sy, en, cyc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, " done seen"}, int'(seen), 1);
    check({name, " reads left"}, addr_q.size(), 0);
    check({name, " plots left"}, plot_q.size(), 0);
  endtask

  initial begin
    int t0;
    bit seen2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset plot", int'(plot), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset rd_en", int'(ram.rd_en), 0);
    check("reset xyc", int'({x, y, colour}), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    mon_en = 1'b1;

    // Plain wall, no sprite.
    start_frame(0, 0, 0, 1'b0);
    wait_done("t1");

    // Scrolled base: first column read is physical column 3.
    start_frame(3, 0, 0, 1'b0);
    wait_done("t2");

    // Sprite clipped on the right and bottom edges.
    start_frame(0, 3, 1, 1'b1);
    wait_done("t3");

    // start held across a whole sweep plus the re-accept cycle.
    @(posedge clk); #1;
    scroll_base = 2'd1; sprite_x = 8'd0; sprite_y = 8'd0; sprite_en = 1'b1;
    start = 1'b1;
    t0 = cyc;
    push_frame(1, 0, 0, 1'b1, t0);
    push_frame(1, 0, 0, 1'b1, t0 + 39);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cyc >= t0 + 37 && cyc <= t0 + 39)
        check("t4 busy", int'(busy), (cyc == t0 + 38) ? 0 : 1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t4");

    // One-cycle reset in the middle of the wall sweep.
    @(posedge clk); #1;
    scroll_base = 2'd0; sprite_en = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 5; k++) addr_q.push_back(k);
    for (int k = 0; k < 4; k++)
      plot_q.push_back({8'(20 + k / 3), 8'(10 + k % 3), (k % 2 == 1) ? 3'b111 : 3'b000});
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    last_pix = '0;
    @(negedge clk);
    check("t5 plot", int'(plot), 0);
    check("t5 busy", int'(busy), 0);
    check("t5 done", int'(done), 0);
    check("t5 rd_en", int'(ram.rd_en), 0);
    check("t5 rd_addr", int'(ram.rd_addr), 0);
    check("t5 xyc", int'({x, y, colour}), 0);
    repeat (50) @(negedge clk);
    check("t5 reads left", addr_q.size(), 0);
    check("t5 plots left", plot_q.size(), 0);
    // Fresh frame with the sprite entirely past the 8-bit edge.
    start_frame(0, 254, 255, 1'b1);
    wait_done("t5b");

    // Out-of-range base on a 5-column map is taken as 0.
    @(posedge clk); #1;
    scroll_base2 = 3'd7;
    start2 = 1'b1;
    for (int k = 0; k < 10; k++) addr2_q.push_back(k);
    @(posedge clk); #1;
    start2 = 1'b0;
    seen2 = 1'b0;
    for (int i = 0; i < 100 && !seen2; i++) begin
      @(negedge clk);
      if (done2) seen2 = 1'b1;
    end
    check("t6 done seen", int'(seen2), 1);
    check("t6 reads left", addr2_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
